// File: rtl/trap_controller_pkg.sv
// rtl/trap_controller_pkg.sv - cause encodings and FSM states shared by the trap sequencer and detector
//
// Contents:
//   CAUSE_*       3-bit trap cause codes, the same values the interrupt detector puts on inter_sel
//   trap_state_t  trap sequencer FSM states
package trap_controller_pkg;

    localparam logic [2:0] CAUSE_NMI    = 3'd0;
    localparam logic [2:0] CAUSE_ECALL  = 3'd1;
    localparam logic [2:0] CAUSE_EBREAK = 3'd2;
    localparam logic [2:0] CAUSE_TMR    = 3'd3;
    localparam logic [2:0] CAUSE_INT    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_T_FLUSH     = 3'd1,
        ST_T_REDIR     = 3'd2,
        ST_HANDLER     = 3'd3,
        ST_NMI_HANDLER = 3'd4,
        ST_R_FLUSH     = 3'd5,
        ST_R_REDIR     = 3'd6
    } trap_state_t;

endpackage

// File: rtl/trap_controller_vector_gen.sv
// rtl/trap_controller_vector_gen.sv - combinational cause to trap vector address
//
// Module trap_vector_gen
//   VEC_BASE  parameter, base of the vector table (one 4-byte slot per cause)
//   cause     in  3   trap cause code
//   addr      out 32  VEC_BASE + cause*4, wrapping modulo 2^32
module trap_vector_gen #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic [2:0]  cause,
    output logic [31:0] addr
);

    assign addr = VEC_BASE + {27'd0, cause, 2'b00};

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - trap sequencer: save PC/cause, flush, vector, and restore on mret
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   inter_flag    in  1   trap request from the detector
//   inter_sel     in  3   cause code from the detector
//   mret          in  1   return-from-trap pulse
//   pc_cur        in  32  resume PC of the oldest uncommitted instruction
//   flush         out 1   kill in-flight instructions (registered)
//   pc_redirect   out 1   fetch loads pc_target (registered)
//   pc_target     out 32  redirect address
//   en_inter      out 1   global interrupt enable back to the detector (registered)
//   mepc, mcause  out     saved PC / cause of the outer trap
//   nmi_epc       out 32  saved PC of a nested NMI
//   in_handler    out 1   any handler active
//   in_nmi        out 1   nested NMI handler active
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inter_flag,
    input  logic [2:0]  inter_sel,
    input  logic        mret,
    input  logic [31:0] pc_cur,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        en_inter,
    output logic [31:0] mepc,
    output logic [2:0]  mcause,
    output logic [31:0] nmi_epc,
    output logic        in_handler,
    output logic        in_nmi
);

    trap_state_t state, state_next;
    logic        nested;
    logic        latch_outer;
    logic        latch_nmi;
    logic        clear_nested;
    logic [2:0]  vec_cause;
    logic [31:0] vec_addr;

    // A nested trap is always the NMI; its cause is not kept in mcause.
    assign vec_cause = nested ? CAUSE_NMI : mcause;

    trap_vector_gen #(.VEC_BASE(VEC_BASE)) u_vector_gen (
        .cause (vec_cause),
        .addr  (vec_addr)
    );

    always_comb begin
        state_next   = state;
        latch_outer  = 1'b0;
        latch_nmi    = 1'b0;
        clear_nested = 1'b0;
        case (state)
            ST_IDLE: begin
                if (inter_flag) begin
                    latch_outer = 1'b1;
                    state_next  = ST_T_FLUSH;
                end
            end
            ST_T_FLUSH:     state_next = ST_T_REDIR;
            ST_T_REDIR:     state_next = nested ? ST_NMI_HANDLER : ST_HANDLER;
            ST_HANDLER: begin
                // NMI takes priority over a coincident mret; other causes are dropped.
                if (inter_flag && inter_sel == CAUSE_NMI) begin
                    latch_nmi  = 1'b1;
                    state_next = ST_T_FLUSH;
                end else if (mret) begin
                    state_next = ST_R_FLUSH;
                end
            end
            ST_NMI_HANDLER: begin
                if (mret) state_next = ST_R_FLUSH;
            end
            ST_R_FLUSH:     state_next = ST_R_REDIR;
            ST_R_REDIR: begin
                if (nested) begin
                    clear_nested = 1'b1;
                    state_next   = ST_HANDLER;
                end else begin
                    state_next   = ST_IDLE;
                end
            end
            default:        state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // cycle the FSM spends in the corresponding state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            nested      <= 1'b0;
            flush       <= 1'b0;
            pc_redirect <= 1'b0;
            pc_target   <= 32'd0;
            en_inter    <= 1'b1;
            mepc        <= 32'd0;
            mcause      <= 3'd0;
            nmi_epc     <= 32'd0;
        end else begin
            state       <= state_next;
            flush       <= (state_next == ST_T_FLUSH) || (state_next == ST_R_FLUSH);
            pc_redirect <= (state_next == ST_T_REDIR) || (state_next == ST_R_REDIR);
            en_inter    <= (state_next == ST_IDLE);
            if (latch_outer) begin
                mepc   <= pc_cur;
                mcause <= inter_sel;
            end
            if (latch_nmi) begin
                nmi_epc <= pc_cur;
                nested  <= 1'b1;
            end else if (clear_nested) begin
                nested  <= 1'b0;
            end
            if (state_next == ST_T_REDIR) begin
                pc_target <= vec_addr;
            end else if (state_next == ST_R_REDIR) begin
                pc_target <= nested ? nmi_epc : mepc;
            end
        end
    end

    assign in_handler = (state != ST_IDLE);
    assign in_nmi     = nested;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - self-checking bench for trap_controller
module tb_trap_controller;

    logic        clk;
    logic        rst;
    logic        inter_flag;
    logic [2:0]  inter_sel;
    logic        mret;
    logic [31:0] pc_cur;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        en_inter;
    logic [31:0] mepc;
    logic [2:0]  mcause;
    logic [31:0] nmi_epc;
    logic        in_handler;
    logic        in_nmi;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    trap_controller #(.VEC_BASE(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .inter_flag  (inter_flag),
        .inter_sel   (inter_sel),
        .mret        (mret),
        .pc_cur      (pc_cur),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target),
        .en_inter    (en_inter),
        .mepc        (mepc),
        .mcause      (mcause),
        .nmi_epc     (nmi_epc),
        .in_handler  (in_handler),
        .in_nmi      (in_nmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the next scoreboard entry into exp; an empty scoreboard is itself a failure.
    task automatic pop_exp(input string name);
        n_cmp++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard empty at t=%0t", name, $time);
            n_bad++;
            exp = 32'hxxxx_xxxx;
        end else begin
            exp = exp_q.pop_front();
        end
    endtask

    task automatic pulse_flag(input logic [31:0] pc, input logic [2:0] sel);
        pc_cur = pc; inter_sel = sel; inter_flag = 1'b1;
        step();
        inter_flag = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inter_flag = 1'b0; inter_sel = 3'd0; mret = 1'b0; pc_cur = 32'd0;
        step(); step();
        n_cmp++; if (en_inter !== 1'b1)      begin $display("FAIL reset_en_inter got %b want 1", en_inter); n_bad++; end
        n_cmp++; if (flush !== 1'b0)         begin $display("FAIL reset_flush got %b want 0", flush); n_bad++; end
        n_cmp++; if (pc_redirect !== 1'b0)   begin $display("FAIL reset_redirect got %b want 0", pc_redirect); n_bad++; end
        n_cmp++; if (pc_target !== 32'd0)    begin $display("FAIL reset_target got %h want 0", pc_target); n_bad++; end
        n_cmp++; if ({mepc, mcause, nmi_epc} !== 67'd0) begin $display("FAIL reset_regs got %h/%h/%h want 0", mepc, mcause, nmi_epc); n_bad++; end
        n_cmp++; if ({in_handler, in_nmi} !== 2'b00) begin $display("FAIL reset_status got %b%b want 00", in_handler, in_nmi); n_bad++; end
        rst = 1'b0;
        step();
    endtask

    task automatic test_timer_trap();
        exp_q.push_back(32'h0000_010C);
        pulse_flag(32'h40, 3'd3);
        n_cmp++; if (flush !== 1'b1)         begin $display("FAIL tmr_flush got %b want 1", flush); n_bad++; end
        n_cmp++; if (pc_redirect !== 1'b0)   begin $display("FAIL tmr_early_redirect got %b want 0", pc_redirect); n_bad++; end
        n_cmp++; if (en_inter !== 1'b0)      begin $display("FAIL tmr_en_inter got %b want 0", en_inter); n_bad++; end
        n_cmp++; if (mepc !== 32'h40)        begin $display("FAIL tmr_mepc got %h want 40", mepc); n_bad++; end
        n_cmp++; if (mcause !== 3'd3)        begin $display("FAIL tmr_mcause got %0d want 3", mcause); n_bad++; end
        step();
        n_cmp++; if ({flush, pc_redirect} !== 2'b01) begin $display("FAIL tmr_redirect got f=%b r=%b want f=0 r=1", flush, pc_redirect); n_bad++; end
        pop_exp("tmr_target");
        n_cmp++; if (pc_target !== exp)      begin $display("FAIL tmr_target got %h want %h", pc_target, exp); n_bad++; end
        step();
        n_cmp++; if ({pc_redirect, in_handler, in_nmi} !== 3'b010) begin $display("FAIL tmr_handler got r=%b h=%b n=%b want 0 1 0", pc_redirect, in_handler, in_nmi); n_bad++; end
    endtask

    task automatic test_return();
        exp_q.push_back(32'h40);
        pulse_mret();
        n_cmp++; if ({flush, pc_redirect} !== 2'b10) begin $display("FAIL ret_flush got f=%b r=%b want f=1 r=0", flush, pc_redirect); n_bad++; end
        step();
        n_cmp++; if (pc_redirect !== 1'b1)   begin $display("FAIL ret_redirect got %b want 1", pc_redirect); n_bad++; end
        pop_exp("ret_target");
        n_cmp++; if (pc_target !== exp)      begin $display("FAIL ret_target got %h want %h", pc_target, exp); n_bad++; end
        n_cmp++; if (en_inter !== 1'b0)      begin $display("FAIL ret_en_early got %b want 0", en_inter); n_bad++; end
        step();
        n_cmp++; if ({en_inter, in_handler, pc_redirect} !== 3'b100) begin $display("FAIL ret_idle got e=%b h=%b r=%b want 1 0 0", en_inter, in_handler, pc_redirect); n_bad++; end
    endtask

    task automatic test_nested_nmi();
        pulse_flag(32'h40, 3'd3);
        step(); step();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h40);
        pulse_flag(32'h200, 3'd0);
        n_cmp++; if ({flush, nmi_epc, in_nmi} !== {1'b1, 32'h200, 1'b1}) begin $display("FAIL nmi_take got f=%b epc=%h n=%b want 1 200 1", flush, nmi_epc, in_nmi); n_bad++; end
        n_cmp++; if ({mepc, mcause} !== {32'h40, 3'd3}) begin $display("FAIL nmi_outer got %h/%0d want 40/3", mepc, mcause); n_bad++; end
        step();
        pop_exp("nmi_vec");
        n_cmp++; if (pc_redirect !== 1'b1 || pc_target !== exp) begin $display("FAIL nmi_vec got r=%b %h want 1 %h", pc_redirect, pc_target, exp); n_bad++; end
        step();
        pulse_mret();
        n_cmp++; if (flush !== 1'b1)         begin $display("FAIL nmi_ret_flush got %b want 1", flush); n_bad++; end
        step();
        pop_exp("nmi_ret_target");
        n_cmp++; if (pc_redirect !== 1'b1 || pc_target !== exp) begin $display("FAIL nmi_ret_target got r=%b %h want 1 %h", pc_redirect, pc_target, exp); n_bad++; end
        step();
        n_cmp++; if ({in_handler, in_nmi, en_inter} !== 3'b100) begin $display("FAIL nmi_back got h=%b n=%b e=%b want 1 0 0", in_handler, in_nmi, en_inter); n_bad++; end
        pulse_mret();
        step();
        pop_exp("outer_ret_target");
        n_cmp++; if (pc_redirect !== 1'b1 || pc_target !== exp) begin $display("FAIL outer_ret_target got r=%b %h want 1 %h", pc_redirect, pc_target, exp); n_bad++; end
        step();
        n_cmp++; if ({in_handler, en_inter} !== 2'b01) begin $display("FAIL outer_ret_idle got h=%b e=%b want 0 1", in_handler, en_inter); n_bad++; end
    endtask

    task automatic test_race();
        exp_q.push_back(32'h104);
        pulse_flag(32'h80, 3'd1);
        step();
        pop_exp("race_ecall_vec");
        n_cmp++; if (pc_target !== exp)      begin $display("FAIL race_ecall_vec got %h want %h", pc_target, exp); n_bad++; end
        step();
        exp_q.push_back(32'h100);
        mret = 1'b1;
        pulse_flag(32'h300, 3'd0);
        mret = 1'b0;
        n_cmp++; if ({flush, in_nmi, mepc} !== {1'b1, 1'b1, 32'h80}) begin $display("FAIL race_nmi got f=%b n=%b mepc=%h want 1 1 80", flush, in_nmi, mepc); n_bad++; end
        step();
        pop_exp("race_vec");
        n_cmp++; if (pc_target !== exp)      begin $display("FAIL race_vec got %h want %h", pc_target, exp); n_bad++; end
        step();
        pulse_mret(); step(); step();
        pulse_mret(); step(); step();
        n_cmp++; if ({in_handler, en_inter} !== 2'b01) begin $display("FAIL race_cleanup got h=%b e=%b want 0 1", in_handler, en_inter); n_bad++; end
    endtask

    task automatic test_drops();
        exp_q.push_back(32'h110);
        pulse_flag(32'h500, 3'd4);
        step();
        pop_exp("drop_int_vec");
        n_cmp++; if (pc_target !== exp)      begin $display("FAIL drop_int_vec got %h want %h", pc_target, exp); n_bad++; end
        step();
        pulse_flag(32'h600, 3'd1);
        n_cmp++; if ({flush, pc_redirect, in_handler} !== 3'b001) begin $display("FAIL drop_ecall got f=%b r=%b h=%b want 0 0 1", flush, pc_redirect, in_handler); n_bad++; end
        n_cmp++; if ({mepc, mcause} !== {32'h500, 3'd4}) begin $display("FAIL drop_regs got %h/%0d want 500/4", mepc, mcause); n_bad++; end
        pulse_mret(); step(); step();
        pulse_mret();
        n_cmp++; if ({flush, pc_redirect, en_inter, in_handler} !== 4'b0010) begin $display("FAIL drop_idle_mret got f=%b r=%b e=%b h=%b want 0 0 1 0", flush, pc_redirect, en_inter, in_handler); n_bad++; end
        step();
        n_cmp++; if ({flush, pc_redirect} !== 2'b00) begin $display("FAIL drop_idle_mret2 got f=%b r=%b want 0 0", flush, pc_redirect); n_bad++; end
    endtask

    task automatic test_async_reset();
        pulse_flag(32'h44, 3'd2);
        step();
        n_cmp++; if (pc_redirect !== 1'b1)   begin $display("FAIL areset_pre got %b want 1", pc_redirect); n_bad++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({pc_redirect, en_inter, in_handler} !== 3'b010) begin $display("FAIL areset_now got r=%b e=%b h=%b want 0 1 0", pc_redirect, en_inter, in_handler); n_bad++; end
        n_cmp++; if ({pc_target, mepc} !== 64'd0) begin $display("FAIL areset_regs got %h/%h want 0/0", pc_target, mepc); n_bad++; end
        #1 rst = 1'b0;
        step(); step();
        n_cmp++; if ({flush, pc_redirect, in_handler} !== 3'b000) begin $display("FAIL areset_no_resume got f=%b r=%b h=%b want 0 0 0", flush, pc_redirect, in_handler); n_bad++; end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_timer_trap();
        test_return();
        test_nested_nmi();
        test_race();
        test_drops();
        test_async_reset();
        n_cmp++; if (exp_q.size() != 0) begin $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); n_bad++; end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequential trap sequencer directly downstream of the interrupt detector. It consumes the detector's `interFlag`/`interSel` pair, saves the interrupted PC and cause, and flushes the pipeline. It then redirects fetch to a per-cause vector and, on `mret`, restores the saved PC. It also drives the global interrupt enable back to the detector (`en_inter`), masking maskable sources while a handler runs.

## Interface
- `VEC_BASE`, default 32'h0000_0100: base of the trap vector table; one 4-byte slot per cause.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inter_flag` in 1: trap request from the detector.
- `inter_sel` in 3: cause code from the detector (encodings under Structure).
- `mret` in 1: decoded return-from-trap, one-cycle pulse.
- `pc_cur` in 32: PC of the oldest uncommitted instruction; this is the resume point.
- `flush` out 1: kill all in-flight instructions.
- `pc_redirect` out 1: fetch must load `pc_target`.
- `pc_target` out 32: redirect address, valid only while `pc_redirect`=1.
- `en_inter` out 1: global enable fed to the detector.
- `mepc` out 32: saved PC of the outer trap.
- `mcause` out 3: cause of the outer trap.
- `nmi_epc` out 32: saved PC of a nested NMI.
- `in_handler` out 1: high whenever any handler is active.
- `in_nmi` out 1: high while a nested NMI handler is active.

## Operation
FSM states: IDLE, T_FLUSH, T_REDIR, HANDLER, NMI_HANDLER, R_FLUSH, R_REDIR. A 1-bit `nested` flag records an NMI that was taken from HANDLER.

- **IDLE**
  - `inter_flag`=1: latch `mepc`←`pc_cur` and `mcause`←`inter_sel`, clear `en_inter`, go to T_FLUSH.
  - `mret`=1: ignored, no redirect.
- **T_FLUSH**: `flush`=1 for one cycle → T_REDIR.
- **T_REDIR**
  - `pc_redirect`=1 for one cycle.
  - `pc_target` = `VEC_BASE` + {cause, 2'b00}, where cause is `mcause`, or NMI if `nested`.
  - Next state: NMI_HANDLER if `nested`, else HANDLER.
- **HANDLER**
  - `inter_flag`=1 with `inter_sel`==NMI: latch `nmi_epc`←`pc_cur`, set `nested`, go to T_FLUSH. `mepc`/`mcause` are untouched.
  - Any other `inter_flag` (e.g. ecall inside a handler): dropped, not queued.
  - `mret`=1: go to R_FLUSH.
- **NMI_HANDLER**
  - Every `inter_flag` is dropped.
  - `mret`=1: go to R_FLUSH.
- **R_FLUSH**: `flush`=1 for one cycle → R_REDIR.
- **R_REDIR**
  - `pc_redirect`=1.
  - If `nested`: `pc_target`=`nmi_epc`, clear `nested`, go to HANDLER; `en_inter` stays 0.
  - Otherwise: `pc_target`=`mepc`, go to IDLE; `en_inter`←1 on entry to IDLE.
- **Simultaneous events**
  - NMI flag and `mret` in the same HANDLER cycle: the NMI wins and `mret` is discarded.
  - `inter_flag` or `mret` during T_*/R_* states: ignored.
- **Status outputs**
  - `in_handler` = state ∉ {IDLE}.
  - `in_nmi` = `nested`.
- **Arithmetic**: `pc_target` is 32-bit unsigned; the vector add wraps modulo 2^32 with no overflow detection.

## Timing
- **Reset values**: state IDLE, `en_inter`=1, `flush`=0, `pc_redirect`=0, `pc_target`=0, `mepc`=0, `mcause`=0, `nmi_epc`=0, `nested`=0, `in_handler`=0, `in_nmi`=0.
- **Trap latency**: flag sampled at edge N.
  - `flush` high in cycle N+1.
  - `pc_redirect` high in cycle N+2.
  - Handler state from N+3.
- **Return latency**: `mret` sampled at edge M.
  - `flush` in M+1.
  - `pc_redirect` in M+2.
  - IDLE and `en_inter`=1 from M+3.
- **Output registration**: `flush`, `pc_redirect` and `en_inter` are registered (Moore) outputs. `pc_target` is registered in the same cycle that `pc_redirect` is asserted.
- **Reset mid-sequence**: `rst` in any state returns all outputs to their reset values asynchronously. The aborted sequence is not resumed.

## Structure
- **Shared defines/package** holds the cause encodings used by both this block and the detector:
  - NMI=3'd0, ECALL=3'd1, EBREAK=3'd2, TMR=3'd3, INT=3'd4.
  - It also holds the FSM state encodings.
- **Sub-module**: one natural sub-module, `trap_vector_gen`, a combinational cause→address function taking `VEC_BASE` as a parameter.
- **Storage**: `mepc`, `mcause` and `nmi_epc` are plain registers in the top; they are not a CSR file.

## Test plan
- **Timer trap**: reset, `pc_cur`=32'h40, pulse `inter_flag` with sel=TMR.
  - `flush` at N+1; `pc_redirect` at N+2 with `pc_target`=32'h10C.
  - `mepc`=32'h40, `mcause`=3, `en_inter`=0.
- **Return**: from the timer trap above, pulse `mret`.
  - `flush` at M+1; `pc_redirect` at M+2 with `pc_target`=32'h40.
  - IDLE with `en_inter`=1 at M+3.
- **Nested NMI**: in HANDLER (`mepc`=32'h40), NMI flag with `pc_cur`=32'h200.
  - `pc_target`=32'h100, `nmi_epc`=32'h200, `in_nmi`=1.
  - `mret` → `pc_target`=32'h200, state HANDLER; second `mret` → `pc_target`=32'h40.
- **Race**: NMI flag and `mret` in the same HANDLER cycle.
  - NMI is taken; `mepc` unchanged; no return redirect.
- **Drops**: ECALL flag while in HANDLER → no `flush`, no state change.
  - `mret` in IDLE → no outputs change.
- **Async reset**: assert `rst` during T_REDIR.
  - `pc_redirect`=0 and `en_inter`=1 immediately, before the next clock edge.
